dsec_session_ctrl: RTL

Session sequencer for the data-stream compression/encryption path. It loads the three 3DES key words, gates data words into the compressor, and ends each message with a dump. It buffers encrypted words in a small output FIFO that drains via the out_valid/out_rcvd handshake, and raises sticky error codes.

---
 rtl/dsec_session_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dsec_session_ctrl.sv
// Session sequencer for the compression/encryption data path.
// Loads the three 3DES key words, gates message words into the compressor,
// requests a dump at end of message, buffers encrypted words in a small
// output FIFO, and latches sticky error codes.
module dsec_session_ctrl #(
  parameter int DATA_W     = 64,
  parameter int OBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              key_config,
  input  logic              msg_last,
  output logic              rdy,
  output logic [2:0]        key_we,
  output logic              comp_valid,
  input  logic              comp_rdy,
  output logic              stall,
  output logic              dump,
  input  logic              scon_done,
  input  logic              enc_valid,
  input  logic [DATA_W-1:0] enc_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rcvd,
  output logic              error,
  output logic [7:0]        error_code
);

  localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, K2, K3, READY, STREAM, DRAIN, ERROR} state_t;

  state_t            state;
  logic              scon_seen;
  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt, cnt_n;
  logic [TW-1:0]     tcnt;
  logic              accept, push, push_eff, pop, full, overflow, to_hit, err_hit;
  logic [7:0]        err_nxt;

  // Host-side handshake: key phase always ready, streaming follows the compressor
  always_comb begin
    rdy = 1'b0;
    case (state)
      IDLE, K2, K3:  rdy = 1'b1;
      READY, STREAM: rdy = comp_rdy && !stall;
      default:       rdy = 1'b0;
    endcase
  end

  assign accept     = in_valid && rdy;
  assign comp_valid = accept && !key_config && (state == READY || state == STREAM);

  // Key write strobe decoded from the state the key word lands in
  always_comb begin
    key_we = 3'b000;
    if (accept && key_config) begin
      case (state)
        IDLE, READY: key_we = 3'b001;
        K2:          key_we = 3'b010;
        K3:          key_we = 3'b100;
        default:     key_we = 3'b000;
      endcase
    end
  end

  assign full      = (cnt == CW'(OBUF_DEPTH));
  assign push      = enc_valid && (state != ERROR);
  assign pop       = out_valid && out_rcvd;
  assign push_eff  = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign to_hit    = out_valid && !out_rcvd && (tcnt == TW'(TIMEOUT - 1));

  // Error detection with fixed priority; nothing new is raised once in ERROR
  always_comb begin
    err_nxt = 8'h00;
    if (state != ERROR) begin
      if (overflow)
        err_nxt = 8'h03;
      else if (to_hit)
        err_nxt = 8'h05;
      else if (state == STREAM && in_valid && key_config)
        err_nxt = 8'h02;
      else if ((state == READY || state == STREAM) && in_valid && !rdy)
        err_nxt = 8'h04;
      else if ((state == IDLE || state == K2 || state == K3) && in_valid && !key_config)
        err_nxt = 8'h01;
    end
  end

  assign err_hit = (err_nxt != 8'h00);

  // Next FIFO occupancy; entering or sitting in ERROR flushes the buffer
  always_comb begin
    cnt_n = cnt + CW'(push_eff) - CW'(pop);
    if (err_hit || state == ERROR) cnt_n = '0;
  end

  // Session FSM with registered dump/stall/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scon_seen  <= 1'b0;
      dump       <= 1'b0;
      stall      <= 1'b0;
      error      <= 1'b0;
      error_code <= 8'h00;
    end else begin
      dump  <= 1'b0;
      stall <= (cnt_n >= CW'(OBUF_DEPTH - 1)) || err_hit || (state == ERROR);
      if (err_hit) begin
        state      <= ERROR;
        error      <= 1'b1;
        error_code <= err_nxt;
        scon_seen  <= 1'b0;
      end else begin
        case (state)
          IDLE:   if (accept) state <= K2;
          K2:     if (accept) state <= K3;
          K3:     if (accept) state <= READY;
          READY, STREAM: begin
            if (accept) begin
              if (key_config) begin
                state <= K2;
              end else if (msg_last) begin
                state <= DRAIN;
                dump  <= 1'b1;
              end else begin
                state <= STREAM;
              end
            end
          end
          DRAIN: begin
            if ((scon_seen || scon_done) && cnt == '0) begin
              state     <= READY;
              scon_seen <= 1'b0;
            end else begin
              scon_seen <= scon_seen || scon_done;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output FIFO storage, pointers and unacknowledged-head timeout counter
  always_ff @(posedge clk) begin
    if (rst || err_hit || state == ERROR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      tcnt   <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= enc_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_n;
      if (pop || cnt == '0)
        tcnt <= '0;
      else if (out_valid && !out_rcvd)
        tcnt <= tcnt + TW'(1);
    end
  end

endmodule
